// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per clock, start/ready handshake.
// Quotient, remainder and divide-by-zero flag are registered and change only on completion.
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             ready,
  output logic             divz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CT_ONE  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] d_reg, d_nx;
  logic [WIDTH-1:0] q_reg, q_nx;
  // Partial remainder is always < divisor between steps, so its top bit is
  // implicitly zero and only WIDTH bits are stored.
  logic [WIDTH-1:0] r_reg, r_nx;
  logic [CW-1:0]    ct, ct_nx;
  logic [WIDTH-1:0] quo_nx, rem_nx;
  logic             ready_nx, divz_nx;

  logic [WIDTH:0]   r_sh, trial;
  logic [WIDTH-1:0] q_sh, q_step, r_step;

  always_comb begin
    r_sh   = {r_reg, q_reg[WIDTH-1]};
    q_sh   = {q_reg[WIDTH-2:0], 1'b0};
    trial  = r_sh - {1'b0, d_reg};
    q_step = q_sh;
    r_step = r_sh[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      q_step = q_sh | WIDTH'(1);
      r_step = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    d_nx     = d_reg;
    q_nx     = q_reg;
    r_nx     = r_reg;
    ct_nx    = ct;
    quo_nx   = quo;
    rem_nx   = rem;
    divz_nx  = divz;
    ready_nx = ready;
    case (state)
      IDLE: begin
        if (start) begin
          d_nx     = dvs;
          q_nx     = dvd;
          r_nx     = '0;
          ct_nx    = CT_INIT;
          ready_nx = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        q_nx  = q_step;
        r_nx  = r_step;
        ct_nx = ct - CT_ONE;
        if (ct == CT_ONE) begin
          quo_nx   = q_step;
          rem_nx   = r_step;
          divz_nx  = (d_reg == '0);
          ready_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      d_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
      ct    <= '0;
      quo   <= '0;
      rem   <= '0;
      divz  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_nx;
      d_reg <= d_nx;
      q_reg <= q_nx;
      r_reg <= r_nx;
      ct    <= ct_nx;
      quo   <= quo_nx;
      rem   <= rem_nx;
      divz  <= divz_nx;
      ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_seq_div4.sv
// Self-checking bench for seq_div4: vector table, busy/reset corner sequences,
// exhaustive and random operands against an arithmetic reference model.
module tb_seq_div4;

  localparam int W = 4;

  logic         clock, reset_n, start;
  logic [W-1:0] dvd, dvs, quo, rem;
  logic         ready, divz;

  int tests = 0;
  int fails = 0;

  seq_div4 #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dvd(dvd), .dvs(dvs),
    .quo(quo), .rem(rem), .ready(ready), .divz(divz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = W'(a / b); r = W'(a % b); z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    if (!ready) check({name, " ready timeout"}, 32'(ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input string name);
    int cnt;
    wait_ready(name);
    dvd = a; dvs = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({name, " busy"}, 32'(ready), 32'd0);
    cnt = 0;
    while (!ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check({name, " run cycles"}, 32'(cnt), 32'(W));
    check({name, " quo"}, 32'(quo), 32'(eq));
    check({name, " rem"}, 32'(rem), 32'(er));
    check({name, " divz"}, 32'(divz), 32'(ez));
  endtask

  initial begin
    logic [W-1:0] mq, mr;
    logic         mz;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 4'd2,  b: 4'd9,  q: 4'd0,  r: 4'd2, z: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
    vecs[5] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, z: 1'b1};
    vecs[6] = '{a: 4'd6,  b: 4'd2,  q: 4'd3,  r: 4'd0, z: 1'b0};
    vecs[7] = '{a: 4'd11, b: 4'd2,  q: 4'd5,  r: 4'd1, z: 1'b0};

    reset_n = 1'b0; start = 1'b0; dvd = '0; dvs = '0;
    #12;
    check("reset quo", 32'(quo), 32'd0);
    check("reset rem", 32'(rem), 32'd0);
    check("reset divz", 32'(divz), 32'd0);
    check("reset ready", 32'(ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));

    // Mid-cycle asynchronous reset clears results immediately.
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async rst quo", 32'(quo), 32'd0);
    check("async rst rem", 32'(rem), 32'd0);
    check("async rst ready", 32'(ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // START pulse during RUN is ignored and not queued.
    dvd = 4'd14; dvs = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dvd = 4'd9; dvs = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("busy pulse");
    check("busy pulse quo", 32'(quo), 32'd2);
    check("busy pulse rem", 32'(rem), 32'd4);
    tick(); tick(); tick();
    check("busy no queue ready", 32'(ready), 32'd1);
    check("busy no queue quo", 32'(quo), 32'd2);

    // START raised for the completion edge only is ignored.
    dvd = 4'd13; dvs = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W - 1; i++) tick();
    check("cmpl edge still busy", 32'(ready), 32'd0);
    dvd = 4'd9; dvs = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("cmpl edge ready", 32'(ready), 32'd1);
    check("cmpl edge quo", 32'(quo), 32'd4);
    tick();
    check("cmpl edge ignored", 32'(ready), 32'd1);

    // START held high: one result every W+1 cycles.
    dvd = 4'd10; dvs = 4'd3; start = 1'b1;
    for (int j = 1; j <= 4 * (W + 1); j++) begin
      tick();
      check($sformatf("held ready e%0d", j), 32'(ready), 32'((j % (W + 1)) == 0));
      if ((j % (W + 1)) == 0) begin
        check($sformatf("held quo e%0d", j), 32'(quo), 32'd3);
        check($sformatf("held rem e%0d", j), 32'(rem), 32'd1);
      end
    end
    start = 1'b0;
    tick();

    // Reset during RUN aborts without presenting a partial result.
    wait_ready("abort");
    dvd = 4'd11; dvs = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort running", 32'(ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort quo", 32'(quo), 32'd0);
    check("abort rem", 32'(rem), 32'd0);
    check("abort divz", 32'(divz), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    #2 reset_n = 1'b1;
    tick(); tick();
    check("abort stays idle", 32'(ready), 32'd1);
    check("abort no result", 32'(quo), 32'd0);
    run_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "after abort");

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        model(W'(a), W'(b), mq, mr, mz);
        run_op(W'(a), W'(b), mq, mr, mz, $sformatf("exh %0d/%0d", a, b));
      end

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      model(ra, rb, mq, mr, mz);
      run_op(ra, rb, mq, mr, mz, $sformatf("rnd %0d/%0d", ra, rb));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_div4.md
# seq_div4

Sequential restoring divider. It is the inverse companion of the team's 4-bit add-shift multiplier benchmark and is built in the same style: START/READY handshake, a down-counting step counter, and one partial-remainder and quotient bit per clock. It divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor and produces a registered quotient and remainder. It sits beside the multiplier as the datapath's divide unit.

## Interface
- WIDTH, default 4: operand, quotient and remainder width; legal range 2 to 16.
- CLOCK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only when READY=1.
- DVD  input  WIDTH  dividend, unsigned; sampled on the START edge.
- DVS  input  WIDTH  divisor, unsigned; sampled on the START edge.
- QUO  output  WIDTH  quotient; registered, updated only on completion.
- REM  output  WIDTH  remainder; registered, updated only on completion.
- READY  output  1  high when idle and results are valid.
- DIVZ  output  1  divisor was zero for the last completed operation; updated on completion.

## Operation
- Reset (async assert, RESET_N=0): QUO=0, REM=0, DIVZ=0, READY=1, state IDLE, step counter CT=0, internal registers cleared.
- States: IDLE and RUN.
- IDLE:
  - READY=1.
  - If START=1 at a clock edge: latch DVS into the D register, DVD into the Q shift register, clear R (WIDTH+1 bits), set CT=WIDTH, go to RUN.
  - If START=0, stay in IDLE.
- RUN, one step per clock:
  - Shift {R,Q} left by 1.
  - Compute trial = R_shifted - {0,D} in WIDTH+1 bits.
  - If trial is non-negative (MSB=0): R=trial and Q[0]=1. Otherwise keep R_shifted and set Q[0]=0.
  - CT decrements by 1.
  - On the step where CT goes 1 to 0:
    - QUO takes the final Q.
    - REM takes the final R[WIDTH-1:0].
    - DIVZ=(D==0).
    - Next state is IDLE.
- Divisor zero: no special path; the algorithm runs the full WIDTH steps and yields QUO=all ones, REM=DVD, DIVZ=1.
- START while in RUN: ignored, with no queuing.
- A new START taken in IDLE does not change QUO, REM or DIVZ until that operation completes.
- Arithmetic: all unsigned. R never exceeds D-1 after a step, so REM fits in WIDTH bits.

## Timing
- START sampled high at edge k with READY=1: READY=0 after edge k.
- Division steps occur at edges k+1 through k+WIDTH.
- QUO, REM, DIVZ and READY=1 all update together at edge k+WIDTH.
- Latency from the START edge to valid results is WIDTH+1 edges (5 for WIDTH=4). READY is low for exactly WIDTH cycles.
- Back-to-back operation: START held high, or reasserted at edge k+WIDTH+1, begins the next operation. Throughput is one result per WIDTH+1 cycles.
- START high at the same edge READY rises (edge k+WIDTH): ignored, because READY was 0 before that edge.
- Reset mid-RUN: abort immediately and apply the reset values. No partial result is ever presented.
- Outputs are glitch-free registers and hold their values indefinitely in IDLE.

## Test plan
- Reset: assert RESET_N=0 mid-cycle -> immediately QUO=0, REM=0, DIVZ=0, READY=1. Release, then START with DVD=13, DVS=3 -> READY low 4 cycles, then QUO=4, REM=1, DIVZ=0 at edge k+4.
- Corner values (WIDTH=4):
  - 15/1 -> QUO=15, REM=0.
  - 2/9 -> QUO=0, REM=2.
  - 15/15 -> QUO=1, REM=0.
  - 0/5 -> QUO=0, REM=0.
- Divide by zero: DVD=7, DVS=0 -> after 4 RUN cycles QUO=15, REM=7, DIVZ=1. A following 6/2 clears DIVZ and yields QUO=3, REM=0.
- Busy handling:
  - Pulse START with 9/4 during RUN of 14/5 -> only QUO=2, REM=4 appear.
  - START high at the completion edge -> ignored.
  - START held high continuously -> one operation every 5 cycles.
- Reset abort: assert RESET_N at RUN step 2 of 11/2 -> outputs 0, READY=1. A new START with 11/2 -> QUO=5, REM=1.
- Exhaustive: all 256 DVD/DVS pairs back-to-back, compared against a reference model (including DVS=0 rule) -> zero mismatches, READY low exactly 4 cycles each.
